// File: rtl/wbframe_arbiter.sv
// Two-master Wishbone arbiter: video reader A (read-only, absolute priority) and frame writer B onto one slave.
// Latency: grant one cycle after cyc is seen in IDLE; slave cycle/strobe/data pass through combinationally.
// Backpressure: non-owner always stalled; owner sees i_stall, plus stall while the outstanding counter is full.
module wbframe_arbiter #(
  parameter int AW    = 24,
  parameter int DW    = 32,
  parameter int LGOUT = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic [AW-1:0]   i_a_addr,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [LGOUT-1:0] CNT_ONE = LGOUT'(1);

  state_t           state, state_nxt;
  logic [LGOUT-1:0] outstanding, outstanding_nxt;
  logic             own_a, own_b;
  logic             owner_cyc, owner_stb;
  logic             cnt_full, accept;

  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign owner_cyc = (own_a & i_a_cyc) | (own_b & i_b_cyc);
  assign owner_stb = (own_a & i_a_stb) | (own_b & i_b_stb);
  // A full counter blocks new strobes instead of wrapping back to zero.
  assign cnt_full  = &outstanding;
  assign accept    = o_stb & ~i_stall;

  assign o_cyc   = owner_cyc;
  assign o_stb   = owner_cyc & owner_stb & ~cnt_full;
  assign o_we    = own_b & i_b_we;
  assign o_addr  = own_a ? i_a_addr : (own_b ? i_b_addr : '0);
  assign o_data  = own_b ? i_b_data : '0;
  assign o_sel   = own_b ? i_b_sel : (own_a ? '1 : '0);
  assign o_rdata = i_data;

  assign o_a_stall = own_a ? (i_stall | cnt_full) : 1'b1;
  assign o_b_stall = own_b ? (i_stall | cnt_full) : 1'b1;
  // Responses only reach a port whose cycle is still open; late ones fall on the floor.
  assign o_a_ack   = own_a & i_a_cyc & i_ack;
  assign o_a_err   = own_a & i_a_cyc & i_err;
  assign o_b_ack   = own_b & i_b_cyc & i_ack;
  assign o_b_err   = own_b & i_b_cyc & i_err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_a_cyc)      state_nxt = OWN_A;
        else if (i_b_cyc) state_nxt = OWN_B;
      end
      OWN_A: if (i_err || !i_a_cyc) state_nxt = IDLE;
      OWN_B: if (i_err || !i_b_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    outstanding_nxt = outstanding;
    if (state == IDLE || i_err || !owner_cyc) begin
      outstanding_nxt = '0;
    end else if (accept && !i_ack) begin
      outstanding_nxt = outstanding + CNT_ONE;
    end else if (!accept && i_ack && (outstanding != '0)) begin
      outstanding_nxt = outstanding - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
    end
  end

endmodule

// File: tb/tb_wbframe_arbiter.sv
// Bench for wbframe_arbiter: random A/B bursts against a slave model, scoreboard queues and a cycle-level grant model.
// Latency: responses checked the cycle they appear at either port or the slave side.
// Backpressure: slave stalls randomly, can withhold acks to saturate the outstanding limit.
module tb_wbframe_arbiter;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int LGOUT = 3;
  localparam int SW    = DW / 8;
  localparam int MAXO  = (1 << LGOUT) - 1;

  logic i_clk = 1'b0, i_reset = 1'b1;
  logic i_a_cyc = 1'b0, i_a_stb = 1'b0;
  logic [AW-1:0] i_a_addr = '0;
  logic o_a_ack, o_a_stall, o_a_err;
  logic i_b_cyc = 1'b0, i_b_stb = 1'b0, i_b_we = 1'b0;
  logic [AW-1:0] i_b_addr = '0;
  logic [DW-1:0] i_b_data = '0;
  logic [SW-1:0] i_b_sel = '0;
  logic o_b_ack, o_b_stall, o_b_err;
  logic [DW-1:0] o_rdata, o_data;
  logic o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [SW-1:0] o_sel;
  logic i_ack = 1'b0, i_stall = 1'b0, i_err = 1'b0;
  logic [DW-1:0] i_data = '0;

  wbframe_arbiter #(.AW(AW), .DW(DW), .LGOUT(LGOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_addr(i_a_addr),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_rdata(o_rdata), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err), .i_data(i_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] sel; } stx_t;
  typedef struct { logic rd; logic [DW-1:0] data; } rsp_t;

  stx_t          slv_exp[$];
  rsp_t          a_exp[$], b_exp[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] ref_mem[16], slv_mem[16];
  int checks = 0, failures = 0;
  int a_ack_cnt = 0, b_ack_cnt = 0, b_err_cnt = 0;
  int saved, wait_cnt;
  bit hold = 0, fast = 0, err_en = 0, force_err = 0, late_ack = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int k = 0; k < SW; k++) if (sel[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [7:0] ctl_vec();
    return {o_cyc, o_stb, o_a_stall, o_b_stall, o_a_ack, o_a_err, o_b_ack, o_b_err};
  endfunction

  // Slave: captures read data at acceptance so later writes cannot leak into earlier reads.
  initial begin : slave
    forever begin
      @(negedge i_clk);
      if (i_reset) pend.delete();
      else begin
        if (o_stb && !i_stall) begin
          pend.push_back(slv_mem[o_addr[3:0]]);
          if (o_we) slv_mem[o_addr[3:0]] = merge(slv_mem[o_addr[3:0]], o_data, o_sel);
        end
        if (i_ack && pend.size() > 0) void'(pend.pop_front());
        if (i_err) pend.delete();
      end
      @(posedge i_clk); #1;
      i_ack   = 1'b0;
      i_err   = 1'b0;
      i_stall = fast ? 1'b0 : ($urandom % 4 == 0);
      if (late_ack) begin
        i_ack = 1'b1;
        late_ack = 0;
      end else if (!hold && pend.size() > 0 && (fast || $urandom % 3 != 0)) begin
        if (force_err || (err_en && $urandom % 20 == 0)) begin
          i_err = 1'b1;
          force_err = 0;
        end else begin
          i_ack  = 1'b1;
          i_data = pend[0];
        end
      end else i_data = $urandom;
    end
  end

  // Reference grant model: who owns the bus and how many requests are in flight.
  int m_own = 0, m_outst = 0;
  logic e_cyc, e_stb, e_full, e_as, e_bs, e_aa, e_ae, e_ba, e_be;
  stx_t s_mon;
  rsp_t r_mon;

  initial begin : monitor
    forever begin
      @(negedge i_clk); #1;
      if (i_reset) begin
        m_own = 0; m_outst = 0;
        a_exp.delete(); b_exp.delete(); slv_exp.delete();
      end
      e_full = (m_outst >= MAXO);
      e_cyc  = (m_own == 1 && i_a_cyc) || (m_own == 2 && i_b_cyc);
      e_stb  = e_cyc && ((m_own == 1 && i_a_stb) || (m_own == 2 && i_b_stb)) && !e_full;
      e_as   = (m_own == 1) ? (i_stall || e_full) : 1'b1;
      e_bs   = (m_own == 2) ? (i_stall || e_full) : 1'b1;
      e_aa   = (m_own == 1) && i_a_cyc && i_ack;
      e_ae   = (m_own == 1) && i_a_cyc && i_err;
      e_ba   = (m_own == 2) && i_b_cyc && i_ack;
      e_be   = (m_own == 2) && i_b_cyc && i_err;
      check("ctl", ctl_vec(), {e_cyc, e_stb, e_as, e_bs, e_aa, e_ae, e_ba, e_be});
      if (o_stb && !i_stall) begin
        if (slv_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL slave_txn: unexpected strobe addr %0h expected none", o_addr);
        end else begin
          s_mon = slv_exp.pop_front();
          check("slave_txn", {o_we, o_addr, o_sel, (o_we ? o_data : 32'h0)},
                {s_mon.we, s_mon.addr, s_mon.sel, (s_mon.we ? s_mon.data : 32'h0)});
        end
      end
      if (o_a_ack) begin
        a_ack_cnt++;
        if (a_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_ack: unexpected ack, expected none");
        end else begin
          r_mon = a_exp.pop_front();
          check("a_rdata", o_rdata, r_mon.data);
        end
      end
      if (o_b_ack) begin
        b_ack_cnt++;
        if (b_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_ack: unexpected ack, expected none");
        end else begin
          r_mon = b_exp.pop_front();
          if (r_mon.rd) check("b_rdata", o_rdata, r_mon.data);
        end
      end
      if (o_a_err) a_exp.delete();
      if (o_b_err) begin b_err_cnt++; b_exp.delete(); end
      if (i_reset) begin
        m_own = 0; m_outst = 0;
      end else if (m_own == 0) begin
        m_own = i_a_cyc ? 1 : (i_b_cyc ? 2 : 0);
        m_outst = 0;
      end else if (i_err || !e_cyc) begin
        m_own = 0; m_outst = 0;
      end else begin
        m_outst = m_outst + ((e_stb && !i_stall) ? 1 : 0) - (i_ack ? 1 : 0);
        if (m_outst < 0) m_outst = 0;
      end
    end
  end

  task automatic burst(input int p, input int n, input bit dir, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] ddata, input logic [SW-1:0] dsel, input logic dwe);
    int issued = 0, done = 0, budget = 0;
    bit abort = 0, hold_stb = 0;
    logic we, stb_s, stall_s;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    stx_t s;
    rsp_t r;
    we   = dir ? dwe : (p == 1 && $urandom % 2 == 0);
    addr = dir ? daddr : AW'($urandom % 16);
    data = dir ? ddata : $urandom;
    sel  = dir ? dsel : SW'($urandom_range(1, 15));
    @(posedge i_clk); #1;
    if (p == 0) i_a_cyc = 1'b1; else i_b_cyc = 1'b1;
    while (!abort && done < n) begin
      stb_s = hold_stb || (issued < n && $urandom % 4 != 0);
      if (p == 0) begin
        i_a_stb = stb_s; i_a_addr = addr;
      end else begin
        i_b_stb = stb_s; i_b_we = we; i_b_addr = addr; i_b_data = data; i_b_sel = sel;
      end
      @(negedge i_clk);
      stall_s  = (p == 0) ? o_a_stall : o_b_stall;
      hold_stb = stb_s && stall_s;
      if (i_reset) abort = 1;
      else begin
        if (stb_s && !stall_s) begin
          s.we = (p == 1) && we; s.addr = addr; s.data = data; s.sel = (p == 0) ? '1 : sel;
          slv_exp.push_back(s);
          r.rd = !s.we; r.data = ref_mem[addr[3:0]];
          if (s.we) ref_mem[addr[3:0]] = merge(ref_mem[addr[3:0]], data, sel);
          if (p == 0) a_exp.push_back(r); else b_exp.push_back(r);
          issued++;
          we   = dir ? dwe : (p == 1 && $urandom % 2 == 0);
          addr = dir ? daddr : AW'($urandom % 16);
          data = dir ? ddata : $urandom;
          sel  = dir ? dsel : SW'($urandom_range(1, 15));
        end
        if ((p == 0) ? o_a_ack : o_b_ack) done++;
        if ((p == 0) ? o_a_err : o_b_err) abort = 1;
      end
      budget++;
      if (budget > 3000) begin
        checks++; failures++;
        $display("FAIL burst_timeout port %0d: acked %0d required %0d", p, done, n);
        abort = 1;
      end
      @(posedge i_clk); #1;
    end
    if (p == 0) begin i_a_cyc = 1'b0; i_a_stb = 1'b0; end
    else begin i_b_cyc = 1'b0; i_b_stb = 1'b0; end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    #2;
    check("reset_state", ctl_vec(), 8'b0011_0000);
    @(posedge i_clk); @(posedge i_clk); #2;
    i_reset = 1'b0;

    // Simultaneous requests: A must win, B waits and then writes.
    saved = b_ack_cnt;
    fork
      burst(0, 2, 1'b0, '0, '0, '0, 1'b0);
      burst(1, 1, 1'b1, 24'h000123, 32'hDEADBEEF, 4'hF, 1'b1);
    join
    check("b_write_acks", b_ack_cnt - saved, 1);
    check("b_write_mem", slv_mem[3], 32'hDEADBEEF);

    fast = 1;
    saved = a_ack_cnt;
    burst(0, 4, 1'b0, '0, '0, '0, 1'b0);
    check("a_burst_acks", a_ack_cnt - saved, 4);

    // Withheld acks drive the outstanding count to its ceiling.
    hold = 1;
    fork
      burst(0, MAXO + 2, 1'b0, '0, '0, '0, 1'b0);
      begin
        wait_cnt = 0;
        while (pend.size() < MAXO && wait_cnt < 200) begin @(negedge i_clk); #2; wait_cnt++; end
        for (int j = 0; j < 3; j++) begin
          @(negedge i_clk); #2;
          check("sat_stall", o_a_stall, 1);
          check("sat_stb", o_stb, 0);
          check("sat_count", pend.size(), MAXO);
        end
        hold = 0;
      end
    join
    fast = 0;

    saved = b_err_cnt;
    force_err = 1;
    burst(1, 3, 1'b0, '0, '0, '0, 1'b0);
    force_err = 0;
    check("b_err_seen", b_err_cnt - saved, 1);
    check("b_err_flush", b_exp.size(), 0);

    err_en = 1;
    fork
      for (int i = 0; i < 25; i++) begin
        burst(0, $urandom_range(1, 6), 1'b0, '0, '0, '0, 1'b0);
        repeat ($urandom_range(0, 4)) @(posedge i_clk);
      end
      for (int i = 0; i < 25; i++) begin
        burst(1, $urandom_range(1, 6), 1'b0, '0, '0, '0, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
      end
    join
    err_en = 0;
    repeat (3) @(posedge i_clk);
    check("a_drained", a_exp.size(), 0);
    check("b_drained", b_exp.size(), 0);
    check("slave_drained", slv_exp.size(), 0);

    // Reset mid-transaction with two reads in flight; a late ack must not surface.
    hold = 1;
    saved = a_ack_cnt;
    fork
      burst(0, 2, 1'b0, '0, '0, '0, 1'b0);
      begin
        wait_cnt = 0;
        while (pend.size() < 2 && wait_cnt < 200) begin @(negedge i_clk); #2; wait_cnt++; end
        check("rst_setup_pending", pend.size(), 2);
        @(negedge i_clk); #3;
        i_reset = 1'b1;
        #1;
        check("rst_immediate", ctl_vec(), 8'b0011_0000);
        @(posedge i_clk); @(posedge i_clk); #2;
        i_reset = 1'b0;
        hold = 0;
        late_ack = 1;
      end
    join
    repeat (4) @(posedge i_clk);
    #1;
    check("late_ack_dropped", a_ack_cnt - saved, 0);
    check("post_reset_idle", ctl_vec(), 8'b0011_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
